// File: rtl/break_select_engine.sv
// break_select_engine: collects one break-status row per clause literal and makes the WalkSAT pick
// (zero-break first, then noise, then minimum break).
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   start_i, lit_valid_i               begin a selection (idle only), literal-present mask
//   in_valid_i, in_ready_o             row beat handshake
//   clause_broken_i, mask_bits_i       per-clause break bits and slot-occupied mask of the current literal
//   random_i                           LFSR value, sampled in the select cycle
//   flush_i                            synchronous abort back to idle
//   out_valid_o, out_ready_i           result handshake
//   selected_o, break_value_o,
//   clause_broken_bits_o, none_valid_o result fields
//   busy_o                             engine not idle
// Optional: define BREAK_SELECT_STATS_EN to add zero_pick_cnt_o, noise_pick_cnt_o, greedy_pick_cnt_o.
module break_select_engine #(
  parameter int          MAX_CLAUSES_PER_VARIABLE      = 20,
  parameter int          NSAT                          = 3,
  parameter int          MAX_CLAUSES_PER_VARIABLE_BITS = 5,
  parameter int          NSAT_BITS                     = 2,
  parameter logic [31:0] P                             = 32'h6E147AE0
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start_i,
  input  logic [NSAT-1:0]                          lit_valid_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]      clause_broken_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]      mask_bits_i,
  input  logic [31:0]                              random_i,
  input  logic                                     flush_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [NSAT_BITS-1:0]                     selected_o,
  output logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0] break_value_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0]      clause_broken_bits_o,
  output logic                                     none_valid_o,
  output logic                                     busy_o
`ifdef BREAK_SELECT_STATS_EN
  ,
  output logic [15:0]                              zero_pick_cnt_o,
  output logic [15:0]                              noise_pick_cnt_o,
  output logic [15:0]                              greedy_pick_cnt_o
`endif
);
  localparam int MC = MAX_CLAUSES_PER_VARIABLE;
  localparam int MCB = MAX_CLAUSES_PER_VARIABLE_BITS;
  localparam logic [MCB-1:0] BRK_MAX = '1;
  typedef enum logic [1:0] {IDLE, COLLECT, SELECT, OUTPUT} state_t;
  state_t                        state_q, state_d;
  logic [NSAT-1:0]               vm_q, vm_d;
  logic [NSAT_BITS-1:0]          idx_q, idx_d;
  logic [NSAT-1:0][MC-1:0]       rows_q, rows_d;
  logic [NSAT-1:0][MCB-1:0]      brk_q, brk_d;
  logic                          out_valid_q, out_valid_d;
  logic [NSAT_BITS-1:0]          sel_q, sel_d;
  logic [MCB-1:0]                bv_q, bv_d;
  logic [MC-1:0]                 bits_q, bits_d;
  logic                          none_q, none_d;
`ifdef BREAK_SELECT_STATS_EN
  logic [15:0]                   zc_q, zc_d, nc_q, nc_d, gc_q, gc_d;
`endif
  logic [MC-1:0]                 row_m;
  logic [31:0]                   pc;
  logic [MCB-1:0]                brk_in;
  logic [NSAT_BITS-1:0]          v_cnt;
  logic                          zero_hit, noise_hit, min_hit, noise_take;
  logic [NSAT_BITS-1:0]          zero_idx, noise_idx, min_idx, pick_idx;
  logic [MCB-1:0]                min_val, pick_brk;
  logic [MC-1:0]                 pick_bits;
  logic [15:0]                   div, k, seen;
  // Masked popcount of the incoming row, saturated to the break-value width.
  always_comb begin
    row_m = clause_broken_i & mask_bits_i;
    pc = '0;
    for (int i = 0; i < MC; i++) pc = pc + 32'(row_m[i]);
    brk_in = (pc > 32'(BRK_MAX)) ? BRK_MAX : pc[MCB-1:0];
  end
  // The three WalkSAT candidates over the stored valid literals.
  always_comb begin
    v_cnt = '0;
    zero_hit = 1'b0;
    zero_idx = '0;
    min_hit = 1'b0;
    min_idx = '0;
    min_val = '0;
    for (int i = 0; i < NSAT; i++) begin
      v_cnt = v_cnt + NSAT_BITS'(vm_q[i]);
      if (vm_q[i] && !zero_hit && brk_q[i] == '0) begin
        zero_hit = 1'b1;
        zero_idx = NSAT_BITS'(i);
      end
      if (vm_q[i] && (!min_hit || brk_q[i] < min_val)) begin
        min_hit = 1'b1;
        min_idx = NSAT_BITS'(i);
        min_val = brk_q[i];
      end
    end
    // Divisor forced to 1 when nothing is valid; that case never uses the noise pick.
    div = (v_cnt == '0) ? 16'd1 : 16'(v_cnt);
    k = random_i[15:0] % div;
    seen = '0;
    noise_hit = 1'b0;
    noise_idx = '0;
    for (int i = 0; i < NSAT; i++) begin
      if (vm_q[i] && !noise_hit && seen == k) begin
        noise_hit = 1'b1;
        noise_idx = NSAT_BITS'(i);
      end
      seen = seen + 16'(vm_q[i]);
    end
    noise_take = random_i < P;
    pick_idx = zero_hit ? zero_idx : noise_take ? noise_idx : min_idx;
    pick_brk = '0;
    pick_bits = '0;
    for (int i = 0; i < NSAT; i++) begin
      if (pick_idx == NSAT_BITS'(i)) begin
        pick_brk = brk_q[i];
        pick_bits = rows_q[i];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    vm_d = vm_q;
    idx_d = idx_q;
    rows_d = rows_q;
    brk_d = brk_q;
    out_valid_d = out_valid_q;
    sel_d = sel_q;
    bv_d = bv_q;
    bits_d = bits_q;
    none_d = none_q;
`ifdef BREAK_SELECT_STATS_EN
    zc_d = zc_q;
    nc_d = nc_q;
    gc_d = gc_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        vm_d = lit_valid_i;
        idx_d = '0;
        state_d = COLLECT;
      end
      COLLECT: if (in_valid_i) begin
        for (int i = 0; i < NSAT; i++) begin
          if (idx_q == NSAT_BITS'(i)) begin
            rows_d[i] = row_m;
            brk_d[i] = brk_in;
          end
        end
        idx_d = (idx_q == NSAT_BITS'(NSAT - 1)) ? '0 : idx_q + NSAT_BITS'(1);
        state_d = (idx_q == NSAT_BITS'(NSAT - 1)) ? SELECT : COLLECT;
      end
      SELECT: begin
        state_d = OUTPUT;
        out_valid_d = 1'b1;
        none_d = v_cnt == '0;
        sel_d = (v_cnt == '0) ? '1 : pick_idx;
        bv_d = (v_cnt == '0) ? '0 : pick_brk;
        bits_d = (v_cnt == '0) ? '0 : pick_bits;
`ifdef BREAK_SELECT_STATS_EN
        if (v_cnt != '0) begin
          if (zero_hit) zc_d = zc_q + 16'(zc_q != 16'hFFFF);
          else if (noise_take) nc_d = nc_q + 16'(nc_q != 16'hFFFF);
          else gc_d = gc_q + 16'(gc_q != 16'hFFFF);
        end
`endif
      end
      OUTPUT: if (out_ready_i) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything above; result fields deliberately keep their last value.
    if (flush_i) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      vm_d = '0;
      idx_d = '0;
      rows_d = '0;
      brk_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vm_q <= '0;
      idx_q <= '0;
      rows_q <= '0;
      brk_q <= '0;
      out_valid_q <= 1'b0;
      sel_q <= '1;
      bv_q <= '0;
      bits_q <= '0;
      none_q <= 1'b0;
`ifdef BREAK_SELECT_STATS_EN
      zc_q <= '0;
      nc_q <= '0;
      gc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      vm_q <= vm_d;
      idx_q <= idx_d;
      rows_q <= rows_d;
      brk_q <= brk_d;
      out_valid_q <= out_valid_d;
      sel_q <= sel_d;
      bv_q <= bv_d;
      bits_q <= bits_d;
      none_q <= none_d;
`ifdef BREAK_SELECT_STATS_EN
      zc_q <= zc_d;
      nc_q <= nc_d;
      gc_q <= gc_d;
`endif
    end
  end
  assign in_ready_o = state_q == COLLECT;
  assign busy_o = state_q != IDLE;
  assign out_valid_o = out_valid_q;
  assign selected_o = sel_q;
  assign break_value_o = bv_q;
  assign clause_broken_bits_o = bits_q;
  assign none_valid_o = none_q;
`ifdef BREAK_SELECT_STATS_EN
  assign zero_pick_cnt_o = zc_q;
  assign noise_pick_cnt_o = nc_q;
  assign greedy_pick_cnt_o = gc_q;
`endif
endmodule

// File: tb/tb_break_select_engine.sv
// tb_break_select_engine: scoreboard bench for break_select_engine with its default parameters.
module tb_break_select_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_i = 1'b0;
  logic [2:0] lit_valid_i = '0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic [19:0] clause_broken_i = '0;
  logic [19:0] mask_bits_i = '0;
  logic [31:0] random_i = '0;
  logic flush_i = 1'b0;
  logic out_valid_o;
  logic out_ready_i = 1'b0;
  logic [1:0] selected_o;
  logic [4:0] break_value_o;
  logic [19:0] clause_broken_bits_o;
  logic none_valid_o;
  logic busy_o;
`ifdef BREAK_SELECT_STATS_EN
  logic [15:0] zc, nc, gc;
`endif
  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  bv;
    logic [19:0] bits;
    logic        none;
  } exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  logic [2:0][19:0] br, mk;
  logic [1:0] last_sel;
  break_select_engine dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .lit_valid_i(lit_valid_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .clause_broken_i(clause_broken_i),
    .mask_bits_i(mask_bits_i), .random_i(random_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .selected_o(selected_o),
    .break_value_o(break_value_o), .clause_broken_bits_o(clause_broken_bits_o),
    .none_valid_o(none_valid_o), .busy_o(busy_o)
`ifdef BREAK_SELECT_STATS_EN
    , .zero_pick_cnt_o(zc), .noise_pick_cnt_o(nc), .greedy_pick_cnt_o(gc)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] lv, input logic [2:0][19:0] b,
                                 input logic [2:0][19:0] m, input logic [31:0] rnd);
    exp_t e;
    int bvs[3];
    int v = 0;
    int pick = -1;
    int c = 0;
    int k;
    int mn = 1000;
    for (int i = 0; i < 3; i++) begin
      bvs[i] = $countones(b[i] & m[i]);
      if (bvs[i] > 31) bvs[i] = 31;
      v += int'(lv[i]);
    end
    e.none = (v == 0);
    e.sel = 2'b11;
    e.bv = '0;
    e.bits = '0;
    if (v == 0) return e;
    for (int i = 0; i < 3; i++) if (lv[i] && bvs[i] == 0 && pick < 0) pick = i;
    if (pick < 0 && rnd < 32'h6E147AE0) begin
      k = int'(rnd[15:0]) % v;
      for (int i = 0; i < 3; i++) begin
        if (lv[i]) begin
          if (c == k && pick < 0) pick = i;
          c++;
        end
      end
    end
    if (pick < 0) begin
      for (int i = 0; i < 3; i++) begin
        if (lv[i] && bvs[i] < mn) begin
          mn = bvs[i];
          pick = i;
        end
      end
    end
    e.sel = pick[1:0];
    e.bv = bvs[pick][4:0];
    e.bits = b[pick] & m[pick];
    return e;
  endfunction
  task automatic rows(input logic [19:0] b0, input logic [19:0] b1, input logic [19:0] b2);
    br[0] = b0;
    br[1] = b1;
    br[2] = b2;
    mk = '1;
  endtask
  task automatic txn(input string tag, input logic [2:0] lv, input logic [31:0] rnd,
                     input int gap, input int hold);
    exp_t e;
    int n;
    int to;
    sbq.push_back(model(lv, br, mk, rnd));
    random_i = rnd;
    @(negedge clk);
    start_i = 1'b1;
    lit_valid_i = lv;
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && gap > 0) begin
        in_valid_i = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          n++;
        end
      end
      in_valid_i = 1'b1;
      clause_broken_i = br[i];
      mask_bits_i = mk[i];
      @(negedge clk);
      n++;
    end
    in_valid_i = 1'b0;
    to = 0;
    while (!out_valid_o && to < 40) begin
      @(negedge clk);
      n++;
      to++;
    end
    chk({tag, "_latency"}, n, 5 + gap);
    e = sbq.pop_front();
    chk({tag, "_sel"}, selected_o, e.sel);
    chk({tag, "_bv"}, break_value_o, e.bv);
    chk({tag, "_bits"}, clause_broken_bits_o, e.bits);
    chk({tag, "_none"}, none_valid_o, e.none);
    in_valid_i = hold > 0;
    clause_broken_i = '1;
    mask_bits_i = '1;
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid_o, 1);
      chk({tag, "_hold_sel"}, selected_o, e.sel);
      chk({tag, "_hold_bv"}, break_value_o, e.bv);
      chk({tag, "_hold_bits"}, clause_broken_bits_o, e.bits);
      chk({tag, "_hold_rdy"}, in_ready_o, 0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk({tag, "_clear"}, out_valid_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
    last_sel = e.sel;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sel", selected_o, 2'b11);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rdy", in_ready_o, 0);
    chk("rst_bv", break_value_o, 0);
    chk("rst_bits", clause_broken_bits_o, 0);
    chk("rst_none", none_valid_o, 0);
    reset_n = 1'b1;
    rows(20'h3, 20'h0, 20'h1);
    txn("zero", 3'b111, 32'hFFFFFFFF, 0, 0);
    rows(20'h7, 20'h3, 20'h5);
    txn("greedy_tie", 3'b111, 32'hFFFFFFFF, 0, 0);
    rows(20'h7, 20'h3, 20'hF);
    txn("noise3", 3'b111, 32'h00000002, 0, 0);
    rows(20'h0, 20'h1F, 20'h7);
    txn("lv101", 3'b101, 32'hFFFFFFFF, 0, 0);
    txn("none", 3'b000, 32'hFFFFFFFF, 0, 0);
    rows(20'h1, 20'h3, 20'h7);
    txn("noise2", 3'b110, 32'h00000003, 0, 0);
    rows(20'hFFFFF, 20'h0, 20'h0);
    mk[0] = '0;
    txn("mask0", 3'b001, 32'hFFFFFFFF, 0, 0);
    rows(20'h0, 20'hFFFFF, 20'h0);
    txn("full20", 3'b010, 32'hFFFFFFFF, 3, 4);
    rows(20'h1, 20'h3, 20'h1);
    txn("noise_hi", 3'b111, 32'h12340005, 0, 0);
    @(negedge clk);
    start_i = 1'b1;
    lit_valid_i = 3'b111;
    @(negedge clk);
    start_i = 1'b0;
    in_valid_i = 1'b1;
    clause_broken_i = 20'h0;
    mask_bits_i = '1;
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_keep_sel", selected_o, last_sel);
    repeat (6) @(negedge clk);
    chk("flush_quiet", out_valid_o, 0);
    rows(20'h7, 20'h3, 20'h5);
    txn("after_flush", 3'b111, 32'hFFFFFFFF, 0, 0);
    @(negedge clk);
    start_i = 1'b1;
    lit_valid_i = 3'b111;
    @(negedge clk);
    start_i = 1'b0;
    in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_sel", selected_o, 2'b11);
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_bv", break_value_o, 0);
    chk("mid_rst_bits", clause_broken_bits_o, 0);
    chk("mid_rst_none", none_valid_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rows(20'h3, 20'h0, 20'h1);
    txn("after_rst", 3'b111, 32'hFFFFFFFF, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
